// File: rtl/frame_streamer.sv
// frame_streamer: reads one H_PIXELS x V_LINES frame from a synchronous-read
// frame buffer in raster order and emits valid/pixel/hcount/vcount beats.
// Ports: clk_in, rst_n_in (async low), start_in (frame request);
//   rd_addr_out/rd_en_out/rd_data_in (frame buffer read port);
//   data_valid_out, pixel_data_out, hcount_out, vcount_out (pixel beat);
//   busy_out (frame in progress), frame_done_out (pulse after last beat).
module frame_streamer #(
    parameter int H_PIXELS     = 320,
    parameter int V_LINES      = 240,
    parameter int READ_LATENCY = 2,
    parameter int LINE_GAP     = 4,
    parameter int ADDR_WIDTH   = 17
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  start_in,
    output logic [ADDR_WIDTH-1:0] rd_addr_out,
    output logic                  rd_en_out,
    input  logic [15:0]           rd_data_in,
    output logic                  data_valid_out,
    output logic [15:0]           pixel_data_out,
    output logic [10:0]           hcount_out,
    output logic [9:0]            vcount_out,
    output logic                  busy_out,
    output logic                  frame_done_out
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [10:0] H_LAST = 11'(H_PIXELS - 1);
    localparam logic [9:0]  V_LAST = 10'(V_LINES - 1);
    localparam int          GAP_END = (LINE_GAP > 0) ? LINE_GAP - 1 : 0;
    localparam logic [3:0]  GAP_LAST = 4'(GAP_END);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    logic [1:0]  state;
    logic [10:0] h_q;
    logic [9:0]  v_q;
    logic [3:0]  gap_cnt;

    // (valid, h, v) of each issued read, delayed to line up with rd_data_in
    logic        pipe_vld [READ_LATENCY];
    logic [10:0] pipe_h   [READ_LATENCY];
    logic [9:0]  pipe_v   [READ_LATENCY];

    // h_q/v_q always describe the address currently on rd_addr_out
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state       <= S_IDLE;
            h_q         <= '0;
            v_q         <= '0;
            gap_cnt     <= '0;
            rd_addr_out <= '0;
            rd_en_out   <= 1'b0;
            busy_out    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start_in && !busy_out) begin
                        state       <= S_READ;
                        busy_out    <= 1'b1;
                        rd_en_out   <= 1'b1;
                        rd_addr_out <= '0;
                        h_q         <= '0;
                        v_q         <= '0;
                    end
                end
                S_READ: begin
                    if (h_q == H_LAST) begin
                        if (v_q == V_LAST) begin
                            state     <= S_DRAIN;
                            rd_en_out <= 1'b0;
                        end else if (LINE_GAP == 0) begin
                            rd_addr_out <= rd_addr_out + ADDR_ONE;
                            h_q         <= '0;
                            v_q         <= v_q + 10'd1;
                        end else begin
                            state     <= S_GAP;
                            rd_en_out <= 1'b0;
                            gap_cnt   <= '0;
                        end
                    end else begin
                        rd_addr_out <= rd_addr_out + ADDR_ONE;
                        h_q         <= h_q + 11'd1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state       <= S_READ;
                        rd_en_out   <= 1'b1;
                        rd_addr_out <= rd_addr_out + ADDR_ONE;
                        h_q         <= '0;
                        v_q         <= v_q + 10'd1;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                S_DRAIN: begin
                    if (frame_done_out) begin
                        state    <= S_IDLE;
                        busy_out <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_vld[i] <= 1'b0;
                pipe_h[i]   <= '0;
                pipe_v[i]   <= '0;
            end
            data_valid_out <= 1'b0;
            pixel_data_out <= '0;
            hcount_out     <= '0;
            vcount_out     <= '0;
            frame_done_out <= 1'b0;
        end else begin
            pipe_vld[0] <= rd_en_out;
            pipe_h[0]   <= h_q;
            pipe_v[0]   <= v_q;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_h[i]   <= pipe_h[i-1];
                pipe_v[i]   <= pipe_v[i-1];
            end
            data_valid_out <= pipe_vld[READ_LATENCY-1];
            if (pipe_vld[READ_LATENCY-1]) begin
                pixel_data_out <= rd_data_in;
                hcount_out     <= pipe_h[READ_LATENCY-1];
                vcount_out     <= pipe_v[READ_LATENCY-1];
            end
            // only the final beat of a frame carries (H_LAST, V_LAST)
            frame_done_out <= data_valid_out &&
                              (hcount_out == H_LAST) &&
                              (vcount_out == V_LAST);
        end
    end

endmodule

// File: tb/tb_frame_streamer.sv
// tb_frame_streamer: directed bench for frame_streamer across four
// configurations; frame buffer model returns mem[a] = a.
module tb_frame_streamer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] start;
    int         total = 0;
    int         bad = 0;
    int         sel = 0;

    always #5 clk = ~clk;

    // A: 4x3, LAT 2, GAP 2
    logic [3:0]  a_addr;
    logic        a_en, a_valid, a_busy, a_done;
    logic [15:0] a_rdata, a_pix, a_d1, a_d2;
    logic [10:0] a_h;
    logic [9:0]  a_v;
    // B: 3x2, LAT 1, GAP 0
    logic [2:0]  b_addr;
    logic        b_en, b_valid, b_busy, b_done;
    logic [15:0] b_rdata, b_pix, b_d1;
    logic [10:0] b_h;
    logic [9:0]  b_v;
    // C: 1x1, LAT 2, GAP 2
    logic [0:0]  c_addr;
    logic        c_en, c_valid, c_busy, c_done;
    logic [15:0] c_rdata, c_pix, c_d1, c_d2;
    logic [10:0] c_h;
    logic [9:0]  c_v;
    // D: 5x3, LAT 4, GAP 3
    logic [3:0]  d_addr;
    logic        d_en, d_valid, d_busy, d_done;
    logic [15:0] d_rdata, d_pix, d_d1, d_d2, d_d3, d_d4;
    logic [10:0] d_h;
    logic [9:0]  d_v;

    frame_streamer #(.H_PIXELS(4), .V_LINES(3), .READ_LATENCY(2),
                     .LINE_GAP(2), .ADDR_WIDTH(4)) u_a (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start[0]),
        .rd_addr_out(a_addr), .rd_en_out(a_en), .rd_data_in(a_rdata),
        .data_valid_out(a_valid), .pixel_data_out(a_pix),
        .hcount_out(a_h), .vcount_out(a_v),
        .busy_out(a_busy), .frame_done_out(a_done));

    frame_streamer #(.H_PIXELS(3), .V_LINES(2), .READ_LATENCY(1),
                     .LINE_GAP(0), .ADDR_WIDTH(3)) u_b (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start[1]),
        .rd_addr_out(b_addr), .rd_en_out(b_en), .rd_data_in(b_rdata),
        .data_valid_out(b_valid), .pixel_data_out(b_pix),
        .hcount_out(b_h), .vcount_out(b_v),
        .busy_out(b_busy), .frame_done_out(b_done));

    frame_streamer #(.H_PIXELS(1), .V_LINES(1), .READ_LATENCY(2),
                     .LINE_GAP(2), .ADDR_WIDTH(1)) u_c (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start[2]),
        .rd_addr_out(c_addr), .rd_en_out(c_en), .rd_data_in(c_rdata),
        .data_valid_out(c_valid), .pixel_data_out(c_pix),
        .hcount_out(c_h), .vcount_out(c_v),
        .busy_out(c_busy), .frame_done_out(c_done));

    frame_streamer #(.H_PIXELS(5), .V_LINES(3), .READ_LATENCY(4),
                     .LINE_GAP(3), .ADDR_WIDTH(4)) u_d (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start[3]),
        .rd_addr_out(d_addr), .rd_en_out(d_en), .rd_data_in(d_rdata),
        .data_valid_out(d_valid), .pixel_data_out(d_pix),
        .hcount_out(d_h), .vcount_out(d_v),
        .busy_out(d_busy), .frame_done_out(d_done));

    // synchronous-read frame buffers, mem[a] = a
    always @(posedge clk) begin
        a_d1 <= 16'(a_addr);
        a_d2 <= a_d1;
        b_d1 <= 16'(b_addr);
        c_d1 <= 16'(c_addr);
        c_d2 <= c_d1;
        d_d1 <= 16'(d_addr);
        d_d2 <= d_d1;
        d_d3 <= d_d2;
        d_d4 <= d_d3;
    end
    assign a_rdata = a_d2;
    assign b_rdata = b_d1;
    assign c_rdata = c_d2;
    assign d_rdata = d_d4;

    logic [16:0] o_addr;
    logic        o_en, o_valid, o_busy, o_done;
    logic [15:0] o_pix;
    logic [10:0] o_h;
    logic [9:0]  o_v;

    always_comb begin
        o_addr  = '0;
        o_en    = 1'b0;
        o_valid = 1'b0;
        o_busy  = 1'b0;
        o_done  = 1'b0;
        o_pix   = '0;
        o_h     = '0;
        o_v     = '0;
        case (sel)
            0: begin
                o_addr = 17'(a_addr); o_en = a_en; o_valid = a_valid;
                o_busy = a_busy; o_done = a_done; o_pix = a_pix;
                o_h = a_h; o_v = a_v;
            end
            1: begin
                o_addr = 17'(b_addr); o_en = b_en; o_valid = b_valid;
                o_busy = b_busy; o_done = b_done; o_pix = b_pix;
                o_h = b_h; o_v = b_v;
            end
            2: begin
                o_addr = 17'(c_addr); o_en = c_en; o_valid = c_valid;
                o_busy = c_busy; o_done = c_done; o_pix = c_pix;
                o_h = c_h; o_v = c_v;
            end
            default: begin
                o_addr = 17'(d_addr); o_en = d_en; o_valid = d_valid;
                o_busy = d_busy; o_done = d_done; o_pix = d_pix;
                o_h = d_h; o_v = d_v;
            end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts one frame on DUT s and checks every beat against raster order.
    // poke: re-pulse start mid-frame and in the frame_done cycle.
    task automatic run_frame(input int s, input int hp, input int vl,
                             input int gap, input int lat, input bit poke);
        int nread = 0;
        int nbeat = 0;
        int ndone = 0;
        int first_rd = -1;
        int first_beat = -1;
        int last_beat = 0;
        int eh, ev;
        bit fin = 1'b0;
        sel = s;
        start[s] = 1'b1;
        @(negedge clk);
        start[s] = 1'b0;
        chk("busy_after_start", 32'(o_busy), 1);
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            if (poke && cyc == 4) start[s] = 1'b1;
            if (poke && cyc == 5) start[s] = 1'b0;
            if (ndone == 1 && !o_done) begin
                chk("busy_low_after_done", 32'(o_busy), 0);
                start[s] = 1'b0;
                fin = 1'b1;
            end else begin
                if (o_en) begin
                    if (nread == 0) first_rd = cyc;
                    chk("rd_addr", 32'(o_addr), nread);
                    nread++;
                end
                if (o_valid) begin
                    eh = nbeat % hp;
                    ev = nbeat / hp;
                    if (nbeat == 0) first_beat = cyc;
                    else chk("beat_spacing", cyc - last_beat - 1,
                             (eh == 0) ? gap : 0);
                    chk("pixel", 32'(o_pix), nbeat);
                    chk("hcount", 32'(o_h), eh);
                    chk("vcount", 32'(o_v), ev);
                    last_beat = cyc;
                    nbeat++;
                end
                if (o_done) begin
                    ndone++;
                    chk("done_delay", cyc - last_beat, 1);
                    chk("done_beats", nbeat, hp * vl);
                    if (poke) start[s] = 1'b1;
                end
                @(negedge clk);
            end
        end
        chk("frame_finished", 32'(fin), 1);
        chk("beats_total", nbeat, hp * vl);
        chk("reads_total", nread, hp * vl);
        chk("done_pulses", ndone, 1);
        chk("first_beat_latency", first_beat - first_rd, lat + 1);
        repeat (4) begin
            @(negedge clk);
            chk("idle_after_frame", 32'({o_en, o_valid, o_busy}), 0);
        end
    endtask

    bit found;

    initial begin
        rst_n = 1'b0;
        start = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(a_busy), 0);
        chk("rst_rd_en", 32'(a_en), 0);
        chk("rst_valid", 32'(a_valid), 0);
        chk("rst_done", 32'(a_done), 0);
        chk("rst_addr", 32'(a_addr), 0);
        chk("rst_beat", 32'({a_pix, a_h, a_v}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // basic frame, then ignored restarts, then a fresh frame
        run_frame(0, 4, 3, 2, 2, 1'b0);
        run_frame(0, 4, 3, 2, 2, 1'b1);
        run_frame(0, 4, 3, 2, 2, 1'b0);

        // reset in the middle of line 1
        sel = 0;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (a_en && a_addr == 4'd6) found = 1'b1;
            else @(negedge clk);
        end
        chk("reach_line1", 32'(found), 1);
        chk("pre_rst_pixel", 32'(a_pix), 3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(a_valid), 0);
        chk("mid_rst_pixel", 32'(a_pix), 0);
        chk("mid_rst_hcount", 32'(a_h), 0);
        chk("mid_rst_vcount", 32'(a_v), 0);
        chk("mid_rst_busy", 32'(a_busy), 0);
        chk("mid_rst_rd_en", 32'(a_en), 0);
        chk("mid_rst_addr", 32'(a_addr), 0);
        chk("mid_rst_done", 32'(a_done), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("no_stale_beat", 32'({a_valid, a_busy, a_en, a_done}), 0);
        end
        run_frame(0, 4, 3, 2, 2, 1'b0);

        // no line gap, single-cycle latency
        run_frame(1, 3, 2, 0, 1, 1'b0);
        // single pixel frame
        run_frame(2, 1, 1, 2, 2, 1'b0);
        // deepest latency
        run_frame(3, 5, 3, 3, 4, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
